// File: rtl/z80_bus_pkg.sv
// rtl/z80_bus_pkg.sv - shared encodings and defaults for the Z80 bus bridge
package z80_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WS   = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   typedef enum logic {
      SP_MEM = 1'b0,
      SP_IO  = 1'b1
   } space_t;

   // Value the CPU sees on an unanswered read (floating Z80 data bus)
   localparam logic [7:0] BUS_IDLE_DATA = 8'hFF;

   localparam int DEF_MIN_WAIT = 0;
   localparam int DEF_TIMEOUT  = 255;

endpackage

// File: rtl/z80_strobe_decode.sv
// rtl/z80_strobe_decode.sv - Z80 strobe decode and re-arm register; intack_det port under Z80_INTACK_EN
module z80_strobe_decode
   import z80_bus_pkg::*;
(
   input  logic   clk,
   input  logic   reset_n,
   input  logic   idle,
   input  logic   mreq_n,
   input  logic   iorq_n,
   input  logic   rd_n,
   input  logic   wr_n,
   input  logic   m1_n,
   input  logic   rfsh_n,
`ifdef Z80_INTACK_EN
   output logic   intack_det,
`endif
   output logic   bus_quiet,
   output logic   start,
   output space_t space,
   output logic   we
);

   logic armed;
   logic intack_cyc;

   // All four strobes released: the CPU is between bus cycles
   assign bus_quiet  = mreq_n & iorq_n & rd_n & wr_n;

   // Interrupt acknowledge is signalled by M1 together with IORQ
   assign intack_cyc = ~m1_n & ~iorq_n;

   assign start = armed & idle & rfsh_n & ~intack_cyc
                & (~rd_n | ~wr_n) & ((~mreq_n) ^ (~iorq_n));

   assign space = mreq_n ? SP_IO : SP_MEM;
   assign we    = ~wr_n;

`ifdef Z80_INTACK_EN
   assign intack_det = armed & idle & intack_cyc;
`endif

   // Only arm after a quiet bus so strobes held across reset never start a cycle
   always_ff @(posedge clk) begin
      if (!reset_n)
         armed <= 1'b0;
      else if (bus_quiet)
         armed <= 1'b1;
   end

endmodule

// File: rtl/z80_bus_bridge.sv
// rtl/z80_bus_bridge.sv - Z80 bus cycle to req/ack bridge; Z80_INTACK_EN adds int_vec/intack
module z80_bus_bridge
   import z80_bus_pkg::*;
#(
   parameter int MIN_WAIT  = DEF_MIN_WAIT,
   parameter int TIMEOUT   = DEF_TIMEOUT,
   parameter int IO_ADDR_W = 8
)
(
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 mreq_n,
   input  logic                 iorq_n,
   input  logic                 rd_n,
   input  logic                 wr_n,
   input  logic                 m1_n,
   input  logic                 rfsh_n,
   input  logic [15:0]          A,
   input  logic [7:0]           cpu_dout,
   output logic [7:0]           cpu_din,
   output logic                 wait_n,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [15:0]          mem_addr,
   output logic [7:0]           mem_wdata,
   input  logic                 mem_ack,
   input  logic [7:0]           mem_rdata,
   output logic                 io_req,
   output logic                 io_we,
   output logic [IO_ADDR_W-1:0] io_addr,
   output logic [7:0]           io_wdata,
   input  logic                 io_ack,
   input  logic [7:0]           io_rdata,
`ifdef Z80_INTACK_EN
   input  logic [7:0]           int_vec,
   output logic                 intack,
`endif
   output logic                 bus_err,
   input  logic                 err_clr
);

   state_t      state_q, state_d;
   space_t      space_q, space_c;
   logic        we_q, we_c;
   logic [15:0] addr_q;
   logic [7:0]  wdata_q;
   logic [7:0]  tmo_q;
   logic [3:0]  ws_q;
   logic        start, bus_quiet;
   logic        ack;
   logic [7:0]  ack_data;
   logic        req_ack, req_tmo;
`ifdef Z80_INTACK_EN
   logic        intack_det;
`endif

   z80_strobe_decode u_decode (
      .clk        (clk),
      .reset_n    (reset_n),
      .idle       (state_q == ST_IDLE),
      .mreq_n     (mreq_n),
      .iorq_n     (iorq_n),
      .rd_n       (rd_n),
      .wr_n       (wr_n),
      .m1_n       (m1_n),
      .rfsh_n     (rfsh_n),
`ifdef Z80_INTACK_EN
      .intack_det (intack_det),
`endif
      .bus_quiet  (bus_quiet),
      .start      (start),
      .space      (space_c),
      .we         (we_c)
   );

   // Next-state: ack beats timeout; one transaction per CPU bus cycle
   always_comb begin
      state_d  = state_q;
      ack      = (space_q == SP_MEM) ? mem_ack : io_ack;
      ack_data = (space_q == SP_MEM) ? mem_rdata : io_rdata;
      req_ack  = 1'b0;
      req_tmo  = 1'b0;
      case (state_q)
         ST_IDLE: begin
`ifdef Z80_INTACK_EN
            if (intack_det)
               state_d = ST_DONE;
            else
`endif
            if (start)
               state_d = ST_REQ;
         end
         ST_REQ: begin
            if (ack) begin
               req_ack = 1'b1;
               state_d = (MIN_WAIT > 0) ? ST_WS : ST_DONE;
            end else if (tmo_q == 8'(TIMEOUT - 1)) begin
               req_tmo = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_WS: begin
            if (ws_q == 4'(MIN_WAIT - 1))
               state_d = ST_DONE;
         end
         ST_DONE: begin
            if (bus_quiet)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // Latch the cycle at start, run the counters, capture read data and errors
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         space_q <= SP_MEM;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         tmo_q   <= '0;
         ws_q    <= '0;
         cpu_din <= BUS_IDLE_DATA;
         bus_err <= 1'b0;
      end else begin
         if (start) begin
            space_q <= space_c;
            we_q    <= we_c;
            addr_q  <= A;
            wdata_q <= cpu_dout;
         end
         tmo_q <= (state_q == ST_REQ) ? tmo_q + 8'd1 : 8'd0;
         ws_q  <= (state_q == ST_WS)  ? ws_q + 4'd1  : 4'd0;
         if (req_ack && !we_q)
            cpu_din <= ack_data;
         else if (req_tmo)
            cpu_din <= BUS_IDLE_DATA;
`ifdef Z80_INTACK_EN
         else if (intack_det)
            cpu_din <= int_vec;
`endif
         if (req_tmo)
            bus_err <= 1'b1;
         else if (err_clr)
            bus_err <= 1'b0;
      end
   end

`ifdef Z80_INTACK_EN
   // One-cycle acknowledge pulse aligned with the vector landing on cpu_din
   always_ff @(posedge clk) begin
      if (!reset_n)
         intack <= 1'b0;
      else
         intack <= intack_det;
   end
`endif

   assign mem_req   = (state_q == ST_REQ) && (space_q == SP_MEM);
   assign io_req    = (state_q == ST_REQ) && (space_q == SP_IO);
   assign mem_we    = we_q && (space_q == SP_MEM);
   assign io_we     = we_q && (space_q == SP_IO);
   assign mem_addr  = addr_q;
   assign io_addr   = addr_q[IO_ADDR_W-1:0];
   assign mem_wdata = wdata_q;
   assign io_wdata  = wdata_q;
   assign wait_n    = ~(start | (state_q == ST_REQ) | (state_q == ST_WS));

endmodule

// File: tb/tb_z80_bus_bridge.sv
// tb/tb_z80_bus_bridge.sv - self-checking bench for z80_bus_bridge (optionally Z80_INTACK_EN)
module tb_z80_bus_bridge;

   localparam int MW = 2;
   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        mreq_n = 1'b1, iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
   logic        m1_n = 1'b1, rfsh_n = 1'b1;
   logic [15:0] A = '0;
   logic [7:0]  cpu_dout = '0;
   logic [7:0]  cpu_din;
   logic        wait_n;
   logic        mem_req, mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_ack = 1'b0;
   logic [7:0]  mem_rdata = '0;
   logic        io_req, io_we;
   logic [7:0]  io_addr;
   logic [7:0]  io_wdata;
   logic        io_ack = 1'b0;
   logic [7:0]  io_rdata = '0;
   logic        bus_err;
   logic        err_clr = 1'b0;
`ifdef Z80_INTACK_EN
   logic [7:0]  int_vec = 8'h00;
   logic        intack;
`endif

   int tests = 0;
   int fails = 0;

   // Model state: what the CPU should currently see
   logic [7:0] exp_din = 8'hFF;
   logic       exp_err = 1'b0;

   always #5 clk = ~clk;

   z80_bus_bridge #(.MIN_WAIT(MW), .TIMEOUT(TO), .IO_ADDR_W(8)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .mreq_n    (mreq_n),
      .iorq_n    (iorq_n),
      .rd_n      (rd_n),
      .wr_n      (wr_n),
      .m1_n      (m1_n),
      .rfsh_n    (rfsh_n),
      .A         (A),
      .cpu_dout  (cpu_dout),
      .cpu_din   (cpu_din),
      .wait_n    (wait_n),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .io_req    (io_req),
      .io_we     (io_we),
      .io_addr   (io_addr),
      .io_wdata  (io_wdata),
      .io_ack    (io_ack),
      .io_rdata  (io_rdata),
`ifdef Z80_INTACK_EN
      .int_vec   (int_vec),
      .intack    (intack),
`endif
      .bus_err   (bus_err),
      .err_clr   (err_clr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic release_bus();
      @(negedge clk);
      mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
      m1_n = 1'b1; rfsh_n = 1'b1;
      mem_ack = 1'b0; io_ack = 1'b0; err_clr = 1'b0;
   endtask

   // One CPU bus cycle; target answers lat cycles after req rises (lat > TO means never in time)
   task automatic do_cycle(input bit is_io, input bit is_wr, input logic [15:0] addr,
                           input logic [7:0] wd, input int lat, input logic [7:0] rd,
                           input bit hold_clr);
      bit          acked, other, done;
      int          nreq, nwait;
      logic [15:0] cap_addr;
      logic [7:0]  cap_wd;
      logic        cap_we;
      acked = (lat <= TO);
      other = 1'b0; done = 1'b0; nreq = 0; nwait = 0;
      cap_addr = '0; cap_wd = '0; cap_we = 1'b0;
      @(negedge clk);
      A = addr; cpu_dout = wd;
      mreq_n = is_io; iorq_n = !is_io;
      rd_n = is_wr;   wr_n = !is_wr;
      m1_n = (is_io || is_wr) ? 1'b1 : 1'($urandom % 2);
      err_clr = hold_clr;
      #1 chk("wait_low_at_strobe", wait_n, 0);
      for (int k = 1; k <= 40 && !done; k++) begin
         @(posedge clk); #1;
         mem_ack = 1'b0; io_ack = 1'b0;
         if (is_io ? mem_req : io_req) other = 1'b1;
         if (is_io ? io_req : mem_req) begin
            if (nreq == 0) begin
               cap_addr = is_io ? {8'h00, io_addr} : mem_addr;
               cap_wd   = is_io ? io_wdata : mem_wdata;
               cap_we   = is_io ? io_we : mem_we;
            end
            nreq++;
         end
         if (!wait_n) nwait++;
         if (k == lat) begin
            if (is_io) begin io_ack = 1'b1; io_rdata = rd; end
            else begin mem_ack = 1'b1; mem_rdata = rd; end
         end else if (k == 1) begin
            // stray ack on the port that was not selected
            if (is_io) begin mem_ack = 1'b1; mem_rdata = ~rd; end
            else begin io_ack = 1'b1; io_rdata = ~rd; end
         end
         if (wait_n) done = 1'b1;
      end
      chk("wait_released", wait_n, 1);
      if (acked) begin
         if (!is_wr) exp_din = rd;
         if (hold_clr) exp_err = 1'b0;
      end else begin
         exp_din = 8'hFF;
         exp_err = 1'b1;
      end
      chk("req_cycles",    nreq,  acked ? lat : TO);
      chk("wait_cycles",   nwait, acked ? lat + MW : TO);
      chk("other_port",    other, 0);
      chk("latched_addr",  cap_addr, is_io ? {8'h00, addr[7:0]} : addr);
      chk("latched_we",    cap_we, is_wr);
      if (is_wr) chk("latched_wdata", cap_wd, wd);
      chk("cpu_din",       cpu_din, exp_din);
      chk("bus_err",       bus_err, exp_err);
      release_bus();
   endtask

   initial begin
      int  pulses;
      bit  seen;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mem_req",  mem_req, 0);
      chk("rst_io_req",   io_req, 0);
      chk("rst_wait_n",   wait_n, 1);
      chk("rst_cpu_din",  cpu_din, 8'hFF);
      chk("rst_bus_err",  bus_err, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_io_addr",  io_addr, 0);
      chk("rst_we",       {mem_we, io_we}, 0);
      @(negedge clk) reset_n = 1'b1;
      repeat (2) @(posedge clk);

      // Memory read, ack after 3 cycles
      do_cycle(1'b0, 1'b0, 16'h1234, 8'h00, 3, 8'h5A, 1'b0);
      // I/O write OUT (40h),C3h, ack after 1 cycle
      do_cycle(1'b1, 1'b1, 16'hAA40, 8'hC3, 1, 8'h00, 1'b0);
      // Unanswered read times out
      do_cycle(1'b0, 1'b0, 16'h2000, 8'h00, 9, 8'h11, 1'b0);
      @(negedge clk) err_clr = 1'b1;
      @(negedge clk) err_clr = 1'b0;
      exp_err = 1'b0;
      chk("err_clr", bus_err, 0);
      // Ack on the same cycle the timeout would fire: ack wins
      do_cycle(1'b1, 1'b0, 16'h0077, 8'h00, TO, 8'h3C, 1'b0);
      // Timeout while err_clr is held: set wins
      do_cycle(1'b1, 1'b0, 16'h0055, 8'h00, TO + 1, 8'h99, 1'b1);

      // Refresh cycle never starts a transaction
      @(negedge clk);
      A = 16'h0042; mreq_n = 1'b0; rfsh_n = 1'b0;
      seen = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (mem_req || io_req || !wait_n) seen = 1'b1;
      end
      chk("refresh_quiet", seen, 0);
      release_bus();

      // Interrupt acknowledge cycle
`ifdef Z80_INTACK_EN
      int_vec = 8'hE7;
`endif
      @(negedge clk);
      m1_n = 1'b0; iorq_n = 1'b0;
      seen = 1'b0; pulses = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (mem_req || io_req || !wait_n) seen = 1'b1;
`ifdef Z80_INTACK_EN
         if (intack) pulses++;
`endif
      end
`ifdef Z80_INTACK_EN
      exp_din = 8'hE7;
      chk("intack_pulses", pulses, 1);
`endif
      chk("intack_quiet", seen, 0);
      chk("intack_din", cpu_din, exp_din);
      release_bus();

      // Reset in the middle of a request with strobes held low
      @(negedge clk);
      A = 16'hBEEF; mreq_n = 1'b0; rd_n = 1'b0;
      @(posedge clk); #1;
      chk("midreq_req", mem_req, 1);
      @(negedge clk) reset_n = 1'b0;
      @(posedge clk); #1;
      chk("reset_drops_req", mem_req, 0);
      chk("reset_din", cpu_din, 8'hFF);
      @(negedge clk) reset_n = 1'b1;
      exp_din = 8'hFF; exp_err = 1'b0;
      seen = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         if (mem_req || io_req || !wait_n) seen = 1'b1;
      end
      chk("no_phantom_cycle", seen, 0);
      release_bus();
      do_cycle(1'b0, 1'b0, 16'hBEEF, 8'h00, 2, 8'hA5, 1'b0);

      // Randomized cycles against the transaction-level model
      for (int n = 0; n < 40; n++) begin
         do_cycle(1'($urandom % 2), 1'($urandom % 2), 16'($urandom), 8'($urandom),
                  int'($urandom_range(1, 6)), 8'($urandom), ($urandom % 5) == 0);
         if ($urandom % 4 == 0) begin
            @(negedge clk) err_clr = 1'b1;
            @(negedge clk) err_clr = 1'b0;
            exp_err = 1'b0;
            chk("rand_err_clr", bus_err, 0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/z80_bus_bridge.md
Name: z80_bus_bridge

Overview:
Sits directly downstream of the negedge-strobed Z80 core wrapper and consumes its bus cycles (mreq_n/iorq_n/rd_n/wr_n/m1_n/rfsh_n, A, data_out). Converts each read or write cycle into a req/ack transaction on a memory port or an I/O port, holding the CPU with wait_n until the transaction completes. Returns read data on cpu_din, with a timeout so an unresponsive target cannot hang the CPU.

Parameters:
MIN_WAIT, 0, extra wait cycles inserted after ack before releasing wait_n (0..15)
TIMEOUT, 255, cycles in REQ without ack before forced completion (1..255)
IO_ADDR_W, 8, width of io_addr (low bits of A)

Ports:
clk  in  1  system clock; bridge runs on posedge
reset_n  in  1  synchronous active-low reset
mreq_n  in  1  CPU memory request strobe
iorq_n  in  1  CPU I/O request strobe
rd_n  in  1  CPU read strobe
wr_n  in  1  CPU write strobe
m1_n  in  1  CPU opcode-fetch / intack marker
rfsh_n  in  1  CPU refresh marker
A  in  16  CPU address
cpu_dout  in  8  CPU write data
cpu_din  out  8  read data to CPU
wait_n  out  1  CPU wait, low = stall
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1 = write
mem_addr  out  16  latched address
mem_wdata  out  8  latched write data
mem_ack  in  1  one-cycle completion from memory
mem_rdata  in  8  memory read data, valid with mem_ack
io_req  out  1  I/O request, held until io_ack
io_we  out  1  1 = write
io_addr  out  IO_ADDR_W  latched A[IO_ADDR_W-1:0]
io_wdata  out  8  latched write data
io_ack  in  1  one-cycle completion from I/O
io_rdata  in  8  I/O read data, valid with io_ack
bus_err  out  1  sticky timeout flag
err_clr  in  1  clears bus_err

Behaviour:
- Reset: state IDLE, armed=0, all req/we = 0, mem_addr/io_addr/wdata = 0, cpu_din = 8'hFF, bus_err = 0, counters = 0. wait_n = 1.
- armed: set when mreq_n, iorq_n, rd_n and wr_n are all high. Cleared by reset. Prevents a phantom cycle from strobes still asserted across reset.
- start = armed & IDLE & rfsh_n & (rd_n==0 | wr_n==0) & (mreq_n==0 XOR iorq_n==0). Refresh cycles and intack (m1_n & iorq_n low, rd_n high) never start.
- wait_n = ~(start | state==REQ | state==WS). It is combinational from the start term, so the first posedge after the strobe edge already sees wait low. The strobes are negedge-registered, so this is a half-cycle path.
- IDLE -> REQ on start:
  - latch A, cpu_dout, we = ~wr_n, space = mreq_n ? IO : MEM.
  - assert the matching req on the next cycle.
- REQ:
  - Hold req, we, addr and wdata stable.
  - On ack: drop req the same edge; for a read, cpu_din <= rdata; go to WS if MIN_WAIT>0, else DONE.
  - When the timeout counter reaches TIMEOUT with no ack: drop req, cpu_din <= 8'hFF, bus_err <= 1, go to DONE.
  - If ack and the timeout fire on the same cycle, ack wins.
- WS: count MIN_WAIT cycles, then DONE.
- DONE: wait_n = 1. Stay until rd_n & wr_n & mreq_n & iorq_n are all high, then IDLE. One transaction per CPU cycle.
- Ack outside REQ, or ack on the non-selected port: ignored.
- err_clr and a timeout on the same cycle: set wins.
- Read-to-CPU latency with immediate ack, MIN_WAIT=0: start edge -> req (1) -> ack (n) -> DONE. cpu_din is valid when wait_n rises.
- Reset mid-transaction: req drops on the reset edge, state goes to IDLE, armed clears.

Optional Feature:
Z80_INTACK_EN.
- Defined:
  - Adds input int_vec[7:0] and output intack (1 cycle).
  - On the first cycle where armed & IDLE & m1_n==0 & iorq_n==0: cpu_din <= int_vec, intack pulses, state goes to DONE.
  - No downstream request; wait_n stays 1.
- Undefined: intack cycles are ignored; cpu_din holds its last value.

Decomposition:
- Package z80_bus_pkg holds:
  - state encoding IDLE/REQ/WS/DONE
  - space encoding MEM/IO
  - BUS_IDLE_DATA = 8'hFF
  - default MIN_WAIT/TIMEOUT constants
- Sub-module z80_strobe_decode: combinational plus the armed register. Produces start, space, we, intack_det.

Test Plan:
- Memory read at A=16'h1234, mem_ack 3 cycles after mem_req with mem_rdata=8'h5A -> mem_req high 3 cycles, mem_addr=16'h1234, mem_we=0, wait_n low until ack+1, cpu_din=8'h5A.
- I/O write OUT (8'h40),8'hC3 with io_ack after 1 cycle, MIN_WAIT=2 -> io_addr=8'h40, io_wdata=8'hC3, io_we=1, wait_n released 2 cycles after ack, no mem_req.
- Refresh cycle (mreq_n=0, rfsh_n=0, rd_n=1) -> no req, wait_n stays 1.
- No ack, TIMEOUT=4 -> req drops after 4 cycles, cpu_din=8'hFF, bus_err=1; err_clr pulse -> bus_err=0.
- Reset asserted mid-REQ with strobes held low -> req=0 immediately; no new req until the strobes go high then low again.
- Z80_INTACK_EN, int_vec=8'hE7, intack cycle -> cpu_din=8'hE7, intack one pulse, wait_n=1, no req.
